// File: rtl/rx_deframer.sv
// Receive-side bit-stream deframer: hunts for a zero preamble and SFD, reads a
// length header, then forwards exactly length*8 payload bits to the output FIFO.
module rx_deframer #(
    parameter int          PREAMBLE_MIN = 8,
    parameter logic [7:0]  SFD          = 8'hA7,
    parameter int          MAX_LEN      = 127
) (
    input  logic       inClock,
    input  logic       inReset,
    input  logic       inBit,
    input  logic       inBitValid,
    input  logic       inFifoFull,
    output logic       outBit,
    output logic       outBitValid,
    output logic       outFrameActive,
    output logic       outFrameDone,
    output logic       outLengthError,
    output logic       outOverflow,
    output logic [6:0] outLength
);

    typedef enum logic [1:0] {
        ST_HUNT    = 2'd0,
        ST_SFD     = 2'd1,
        ST_LEN     = 2'd2,
        ST_PAYLOAD = 2'd3
    } state_t;

    state_t     r_state;
    logic [7:0] r_zero_run;
    logic [6:0] r_shift;
    logic [2:0] r_bit_cnt;
    logic [9:0] r_remain;
    logic       r_out_bit;
    logic       r_out_valid;
    logic       r_done;
    logic       r_len_err;
    logic       r_overflow;
    logic [6:0] r_length;

    state_t     w_state_nxt;
    logic [7:0] w_zero_run_nxt;
    logic [6:0] w_shift_nxt;
    logic [2:0] w_bit_cnt_nxt;
    logic [9:0] w_remain_nxt;
    logic       w_out_bit_nxt;
    logic       w_out_valid_nxt;
    logic       w_done_nxt;
    logic       w_len_err_nxt;
    logic       w_overflow_nxt;
    logic [6:0] w_length_nxt;

    // Byte as it would look with the current bit shifted in (LSB first).
    logic [7:0] w_byte;
    logic [6:0] w_len;
    assign w_byte = {inBit, r_shift};
    assign w_len  = w_byte[6:0];

    always_comb begin
        w_state_nxt     = r_state;
        w_zero_run_nxt  = r_zero_run;
        w_shift_nxt     = r_shift;
        w_bit_cnt_nxt   = r_bit_cnt;
        w_remain_nxt    = r_remain;
        w_out_bit_nxt   = 1'b0;
        w_out_valid_nxt = 1'b0;
        w_done_nxt      = 1'b0;
        w_len_err_nxt   = 1'b0;
        w_overflow_nxt  = r_overflow;
        w_length_nxt    = r_length;

        if (inBitValid) begin
            case (r_state)
                ST_HUNT: begin
                    if (!inBit) begin
                        if (r_zero_run != 8'hFF)
                            w_zero_run_nxt = r_zero_run + 8'd1;
                    end else if (r_zero_run >= PREAMBLE_MIN[7:0]) begin
                        w_shift_nxt   = {inBit, 6'b0};
                        w_bit_cnt_nxt = 3'd1;
                        w_state_nxt   = ST_SFD;
                    end else begin
                        w_zero_run_nxt = 8'd0;
                    end
                end
                ST_SFD: begin
                    w_shift_nxt   = w_byte[7:1];
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        w_bit_cnt_nxt = 3'd0;
                        if (w_byte == SFD) begin
                            w_state_nxt    = ST_LEN;
                            w_overflow_nxt = 1'b0;
                        end else begin
                            // Mismatching bits are discarded, not rescanned.
                            w_state_nxt    = ST_HUNT;
                            w_zero_run_nxt = 8'd0;
                        end
                    end
                end
                ST_LEN: begin
                    w_shift_nxt   = w_byte[7:1];
                    w_bit_cnt_nxt = r_bit_cnt + 3'd1;
                    if (r_bit_cnt == 3'd7) begin
                        if (w_len == 7'd0 || w_len > MAX_LEN[6:0]) begin
                            w_len_err_nxt  = 1'b1;
                            w_state_nxt    = ST_HUNT;
                            w_zero_run_nxt = 8'd0;
                        end else begin
                            w_length_nxt = w_len;
                            w_remain_nxt = {w_len, 3'b000};
                            w_state_nxt  = ST_PAYLOAD;
                        end
                    end
                end
                ST_PAYLOAD: begin
                    // A dropped bit still consumes one slot of the frame.
                    w_remain_nxt = r_remain - 10'd1;
                    if (!inFifoFull) begin
                        w_out_valid_nxt = 1'b1;
                        w_out_bit_nxt   = inBit;
                    end else begin
                        w_overflow_nxt = 1'b1;
                    end
                    if (r_remain == 10'd1) begin
                        w_done_nxt     = 1'b1;
                        w_state_nxt    = ST_HUNT;
                        w_zero_run_nxt = 8'd0;
                    end
                end
                default: w_state_nxt = ST_HUNT;
            endcase
        end
    end

    always_ff @(posedge inClock) begin
        if (inReset) begin
            r_state     <= ST_HUNT;
            r_zero_run  <= 8'd0;
            r_shift     <= 7'd0;
            r_bit_cnt   <= 3'd0;
            r_remain    <= 10'd0;
            r_out_bit   <= 1'b0;
            r_out_valid <= 1'b0;
            r_done      <= 1'b0;
            r_len_err   <= 1'b0;
            r_overflow  <= 1'b0;
            r_length    <= 7'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_zero_run  <= w_zero_run_nxt;
            r_shift     <= w_shift_nxt;
            r_bit_cnt   <= w_bit_cnt_nxt;
            r_remain    <= w_remain_nxt;
            r_out_bit   <= w_out_bit_nxt;
            r_out_valid <= w_out_valid_nxt;
            r_done      <= w_done_nxt;
            r_len_err   <= w_len_err_nxt;
            r_overflow  <= w_overflow_nxt;
            r_length    <= w_length_nxt;
        end
    end

    assign outBit         = r_out_bit;
    assign outBitValid    = r_out_valid;
    assign outFrameActive = (r_state == ST_LEN) || (r_state == ST_PAYLOAD);
    assign outFrameDone   = r_done;
    assign outLengthError = r_len_err;
    assign outOverflow    = r_overflow;
    assign outLength      = r_length;

endmodule

// File: doc/rx_deframer.md
# rx_deframer

Receive-path bit-stream deframer between the CDR (`o_data`/`o_flag`) and the outFIFO (`inWriteEnable`/`inData`). It is the receive-side counterpart of the transmit framing that feeds the inFIFO→MSK modulator path. It hunts for a zero preamble and a start-of-frame delimiter (SFD), reads a length header, then forwards exactly length×8 payload bits to the outFIFO and flags frame completion or errors.

## Interface
- `PREAMBLE_MIN`, 8: minimum consecutive zero bits required before an SFD is accepted (1–255).
- `SFD`, 8'hA7: start-of-frame delimiter, received LSB first; bit 0 must be 1.
- `MAX_LEN`, 127: largest legal payload length in bytes (1–127).

Ports:
- `inClock` in 1: the single clock.
- `inReset` in 1: reset, synchronous, active-high.
- `inBit` in 1: recovered data bit from the CDR.
- `inBitValid` in 1: one-cycle strobe; `inBit` is valid in that cycle.
- `inFifoFull` in 1: outFIFO full.
- `outBit` out 1: payload bit to the outFIFO.
- `outBitValid` out 1: outFIFO write enable, one cycle per payload bit.
- `outFrameActive` out 1: high while in the LEN or PAYLOAD state.
- `outFrameDone` out 1: one-cycle pulse after the last payload bit.
- `outLengthError` out 1: one-cycle pulse when a header is rejected.
- `outOverflow` out 1: sticky per frame; at least one payload bit was dropped because the FIFO was full.
- `outLength` out 7: length of the current or last accepted frame, in bytes.

## Operation
- All state advances only on cycles with `inBitValid`=1. Bits are always LSB first.
- Back-to-back `inBitValid` on consecutive cycles is supported at one bit per cycle.
- The state machine has four states: HUNT, SFD, LEN and PAYLOAD.
- **HUNT**
  - A 0 bit increments `zeroRun`, an 8-bit counter that saturates at 255.
  - On a 1 bit with `zeroRun` ≥ `PREAMBLE_MIN`: load `sfdShift` with the bit, set `bitCnt`=1 and go to SFD.
  - On a 1 bit otherwise: clear `zeroRun`.
- **SFD**
  - Shift bits in until 8 bits have been collected.
  - On the 8th bit, compare against `SFD`.
  - Match: go to LEN, clear `outOverflow`, clear `bitCnt`.
  - Mismatch: go to HUNT with `zeroRun`=0. The mismatching bits are not rescanned.
- **LEN**
  - Collect 8 bits into the PHR byte. Bit 7 is reserved and ignored; `len` = PHR[6:0].
  - If `len`=0 or `len` > `MAX_LEN`: pulse `outLengthError`, go to HUNT with `zeroRun`=0. `outLength` is unchanged.
  - Otherwise: set `outLength`=`len`, load the 10-bit counter `remain`=`len`×8, go to PAYLOAD.
- **PAYLOAD**
  - Each valid bit decrements `remain`.
  - If `inFifoFull`=0 in that cycle, the bit is forwarded.
  - If `inFifoFull`=1, the bit is dropped and `outOverflow` is set. The bit still counts toward `remain`.
  - On the bit that takes `remain` to 0: pulse `outFrameDone`, go to HUNT with `zeroRun`=0.
- Frames are neither retried nor truncated; timing of the payload is set only by the bit count.

## Timing
- All outputs are registered. Latency from `inBitValid` to `outBitValid`/`outBit` is 1 cycle.
- `outFrameDone` asserts in the same cycle as the `outBitValid` of the final bit. If the final bit was dropped, `outFrameDone` asserts alone in that cycle.
- `outLengthError` asserts 1 cycle after the 8th PHR bit.
- `outFrameActive` rises 1 cycle after the SFD-completing bit. It falls 1 cycle after the final payload bit or the rejected PHR bit.
- `inFifoFull` is sampled in the same cycle as `inBitValid`.
- `outLength` updates 1 cycle after the 8th PHR bit.
- `outOverflow` clears 1 cycle after the SFD match.
- Reset, including mid-frame:
  - State returns to HUNT; `zeroRun`, `bitCnt` and `remain` go to 0.
  - Every output goes to 0 on the next edge, including `outLength`=0 and `outOverflow`=0.
  - No `outFrameDone` is generated for an aborted frame.
- `inBitValid`=0 cycles have no effect; gaps of any length between bits are legal.

## Test plan
- **Nominal frame**: 8 zeros, SFD 0xA7, PHR 0x02, payload 0x3C 0x81, bits back-to-back.
  - 16 `outBitValid` pulses carrying 0,0,1,1,1,1,0,0, 1,0,0,0,0,0,0,1.
  - `outLength`=2; `outFrameDone` coincides with the 16th write; `outOverflow`=0.
- **Short preamble**: 7 zeros then 0xA7, PHR 0x02, payload.
  - No `outBitValid`, `outFrameActive` stays 0.
  - A following correct frame (8 zeros, SFD, PHR 0x01, 0xFF) yields 8 writes of 1.
- **Bad SFD / bad length**:
  - 8 zeros + 0xA6: no output, no error pulse.
  - 8 zeros + 0xA7 + PHR 0x80 (len 0): one `outLengthError` pulse.
  - With `MAX_LEN`=16 and PHR 0x14: one `outLengthError`, `outLength` unchanged.
- **Overflow**: nominal frame with `inFifoFull`=1 during payload bits 3 and 4.
  - 14 writes; `outOverflow` rises after bit 3 and stays high.
  - `outFrameDone` still pulses.
  - `outOverflow` clears after the next frame's SFD.
- **Gapped input and mid-frame reset**:
  - Nominal frame with random 0–5 cycle gaps gives results identical to the nominal case.
  - `inReset` asserted after the 5th payload bit: all outputs are 0 next cycle, no `outFrameDone`.
  - A new frame afterwards decodes correctly.
